// File: rtl/key_evt_pkg.sv
// key_evt_pkg: shared state type, clog2 helper and default timing constants for key event decoding
package key_evt_pkg;
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} key_state_t;
  localparam int CLK_HZ = 50_000_000;
  localparam int DEF_DEBOUNCE_CYC = 8192;
  localparam int DEF_LONG_CYC = CLK_HZ;
  localparam int DEF_REPEAT_CYC = CLK_HZ / 5;
  function automatic int clog2(input longint v);
    int r;
    r = 0;
    while ((64'd1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel (2-flop sync, debounce, press/release/long FSM)
// KEY_REPEAT_EN adds the auto-repeat counter in HELD; otherwise repeat_pulse is tied low
module key_debounce_ch
  import key_evt_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC = DEF_LONG_CYC
`ifdef KEY_REPEAT_EN
  , parameter int REPEAT_CYC = DEF_REPEAT_CYC
`endif
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);
  localparam int DW = clog2(DEBOUNCE_CYC + 1);
  localparam int HW = clog2(LONG_CYC + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYC);
  localparam logic [HW-1:0] LONG_M1 = HW'(LONG_CYC - 1);
  logic key_meta, key_sync, tog, rise, fall;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  key_state_t state;
  always_comb begin
    tog = (key_sync != key_level) && (db_cnt == DB_MAX);
    rise = tog & ~key_level;
    fall = tog & key_level;
  end
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
      db_cnt <= '0;
      key_level <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse <= 1'b0;
      hold_cnt <= '0;
      state <= IDLE;
    end else begin
      key_meta <= key_in;
      key_sync <= key_meta;
      db_cnt <= (key_sync == key_level || tog) ? '0 : db_cnt + DW'(1);
      key_level <= key_level ^ tog;
      press_pulse <= rise;
      release_pulse <= fall;
      long_pulse <= 1'b0;
      if (fall) begin
        state <= IDLE;
        hold_cnt <= '0;
      end else if (rise) begin
        state <= PRESSED;
        hold_cnt <= '0;
      end else if (state == PRESSED) begin
        hold_cnt <= hold_cnt + HW'(1);
        if (hold_cnt == LONG_M1) begin
          state <= HELD;
          long_pulse <= 1'b1;
        end
      end
    end
  end
`ifdef KEY_REPEAT_EN
  localparam int RW = clog2(REPEAT_CYC + 1);
  localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYC);
  localparam logic [RW-1:0] RPT_M1 = RW'(REPEAT_CYC - 1);
  logic [RW-1:0] rpt_cnt;
  logic in_held;
  always_comb in_held = (state == HELD) && !fall;
  // counts 1..REPEAT_CYC while held; pulse lands on the cycle the count reaches REPEAT_CYC
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      rpt_cnt <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      rpt_cnt <= in_held ? ((rpt_cnt == RPT_MAX) ? RW'(1) : rpt_cnt + RW'(1)) : '0;
      repeat_pulse <= in_held && (rpt_cnt == RPT_M1);
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif
endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: debounced per-key press/release/long(/repeat with KEY_REPEAT_EN) pulse generator
module key_event_gen
  import key_evt_pkg::*;
#(
  parameter int NUM_KEYS = 2,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC = DEF_LONG_CYC
`ifdef KEY_REPEAT_EN
  , parameter int REPEAT_CYC = DEF_REPEAT_CYC
`endif
) (
  input  logic                clk_50m,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC(LONG_CYC)
`ifdef KEY_REPEAT_EN
      , .REPEAT_CYC(REPEAT_CYC)
`endif
    ) u_ch (
      .clk_50m(clk_50m),
      .rst_n(rst_n),
      .key_in(key_in[i]),
      .key_level(key_level[i]),
      .press_pulse(press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse(long_pulse[i]),
      .repeat_pulse(repeat_pulse[i])
    );
  end
endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: directed checks of debounce latency, glitch rejection, long press, repeat and reset
module tb_key_event_gen;
  logic clk_50m = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] key_in = 2'b00;
  logic [1:0] key_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
  int checks = 0;
  int errors = 0;
  int np[2], nr[2], nl[2], nrep[2], fp[2], fr[2], fl[2], frep[2];
  logic [1:0] stim[$];
`ifdef KEY_REPEAT_EN
  localparam int EXP_REP = 3;
`else
  localparam int EXP_REP = 0;
`endif

  key_event_gen #(
    .NUM_KEYS(2),
    .DEBOUNCE_CYC(4),
    .LONG_CYC(20)
`ifdef KEY_REPEAT_EN
    , .REPEAT_CYC(5)
`endif
  ) dut (
    .clk_50m(clk_50m),
    .rst_n(rst_n),
    .key_in(key_in),
    .key_level(key_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk_50m = ~clk_50m;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) stim.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  // cycle c is the state just after the c-th edge from the start of the run
  task automatic run(input int n);
    for (int k = 0; k < 2; k++) begin
      np[k] = 0; nr[k] = 0; nl[k] = 0; nrep[k] = 0;
      fp[k] = -1; fr[k] = -1; fl[k] = -1; frep[k] = -1;
    end
    for (int c = 0; c < n; c++) begin
      if (stim.size() > 0) key_in = stim.pop_front();
      tick();
      for (int k = 0; k < 2; k++) begin
        if (press_pulse[k]) begin np[k]++; if (fp[k] < 0) fp[k] = c; end
        if (release_pulse[k]) begin nr[k]++; if (fr[k] < 0) fr[k] = c; end
        if (long_pulse[k]) begin nl[k]++; if (fl[k] < 0) fl[k] = c; end
        if (repeat_pulse[k]) begin nrep[k]++; if (frep[k] < 0) frep[k] = c; end
      end
    end
  endtask

  initial begin
    key_in = 2'b11;
    repeat (3) tick();
    check("rst_outs", int'({key_level, press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
    rst_n = 1'b1;
    push(2'b11, 1);
    run(10);
    check("t1_press0_cyc", fp[0], 6);
    check("t1_press1_cyc", fp[1], 6);
    check("t1_press_cnt", np[0] + np[1], 2);
    check("t1_level", int'(key_level), 3);
    push(2'b00, 1);
    run(10);
    check("t1_rel0_cyc", fr[0], 6);
    check("t1_rel1_cyc", fr[1], 6);

    push(2'b01, 3); push(2'b00, 1);
    run(12);
    check("t2_press_cnt", np[0], 0);
    check("t2_rel_cnt", nr[0], 0);
    check("t2_level", int'(key_level[0]), 0);

    push(2'b01, 10); push(2'b00, 1);
    run(30);
    check("t3_press_cyc", fp[0], 6);
    check("t3_press_cnt", np[0], 1);
    check("t3_rel_cyc", fr[0], 16);
    check("t3_long_cnt", nl[0], 0);

    push(2'b10, 40); push(2'b00, 1);
    run(60);
    check("t4_press_cyc", fp[1], 6);
    check("t4_long_cyc", fl[1], 26);
    check("t4_long_cnt", nl[1], 1);
    check("t4_rel_cyc", fr[1], 46);
    check("t4_rep_cnt", nrep[1], EXP_REP);
    check("t4_key0_quiet", np[0] + nr[0] + nl[0], 0);
`ifdef KEY_REPEAT_EN
    check("t4_rep_first", frep[1], 31);
`endif

    stim = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    run(20);
    check("t5_press_cnt", np[0], 1);
    check("t5_press_cyc", fp[0], 11);
    push(2'b00, 1);
    run(10);
    check("t5_rel_cyc", fr[0], 6);

    push(2'b10, 1);
    run(30);
    check("t6_pre_long", nl[1], 1);
    rst_n = 1'b0;
    tick();
    check("t6_rst_outs", int'({key_level, press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
    tick();
    rst_n = 1'b1;
    run(40);
    check("t6_press_cyc", fp[1], 6);
    check("t6_long_cyc", fl[1], 26);
    check("t6_long_cnt", nl[1], 1);
    push(2'b00, 1);
    run(10);
    check("t6_rel_cyc", fr[1], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
